width_downconv_fifo: RTL

- Parametrised successor of the fixed 64-to-8 FIFO/unpacker.
- Buffers wide input words in a DEPTH-entry FIFO, then serialises each word into OUT_W-bit slices on request. Each word carries its own valid-slice count, so partial words are supported.
- Configurable slice order, back-to-back word streaming with no inter-word bubble, and fill-level/almost-full status.
- Sits between the wide packet source and the narrow byte-oriented output stage.

---
 rtl/width_downconv_fifo.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/width_downconv_fifo.sv
// rtl/width_downconv_fifo.sv - buffered wide-to-narrow word serialiser with per-word slice count
//
// Purpose: stores IN_W-bit words (each tagged with a valid-slice count) in a
// DEPTH-entry FIFO and serialises them into OUT_W-bit slices on req_data.
// Words stream back to back with no bubble between the last slice of one word
// and the first slice of the next.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   strobe_in         write request (dropped while full)
//   input_data        word to store
//   input_len         valid slices in the word minus 1
//   req_data          sink requests one slice this cycle
//   strobe_out        data_out carries a valid slice
//   data_out          output slice (holds last value when idle)
//   data_end          last slice of a word, qualified by strobe_out
//   ready             FIFO empty and serialiser idle
//   full, almost_full FIFO status (combinational from pointers)
//   level             words in FIFO, excluding the one being serialised
//   overflow_cnt      saturating dropped-write counter (only with WDC_OVF_CNT_EN)
//
// Optional feature macro: WDC_OVF_CNT_EN

module width_downconv_fifo #(
  parameter int IN_W      = 64,
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 8,
  parameter int AFULL_THR = 6,
  parameter int MSB_FIRST = 1,
  parameter int LEN_W     = $clog2(IN_W / OUT_W),
  parameter int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe_in,
  input  logic [IN_W-1:0]  input_data,
  input  logic [LEN_W-1:0] input_len,
  input  logic             req_data,
  output logic             strobe_out,
  output logic [OUT_W-1:0] data_out,
  output logic             data_end,
  output logic             ready,
  output logic             full,
  output logic             almost_full,
  output logic [LVL_W-1:0] level
`ifdef WDC_OVF_CNT_EN
  ,
  output logic [15:0]      overflow_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_EMPTY = 1'b0, ST_SHIFT = 1'b1} state_t;

  state_t state, state_nxt;

  logic [LEN_W+IN_W-1:0] mem [DEPTH];
  logic [LVL_W-1:0]      wr_ptr, rd_ptr;
  logic [IN_W-1:0]       hold_data;
  logic [LEN_W-1:0]      hold_len;
  logic [LEN_W-1:0]      idx;

  logic empty, wr_en, load, emit, last;

  // Pointer-derived status; the extra MSB of each pointer is the wrap bit.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign level       = wr_ptr - rd_ptr;
  assign almost_full = (level >= LVL_W'(AFULL_THR));
  assign ready       = empty && (state == ST_EMPTY);

  // full is taken before the edge, so a same-cycle read never frees a slot
  // for this write.
  assign wr_en = strobe_in && !full;
  assign last  = (idx == hold_len);

  function automatic logic [OUT_W-1:0] slice_of(input logic [IN_W-1:0] w,
                                                input logic [LEN_W-1:0] i);
    logic [IN_W-1:0] sh;
    if (MSB_FIRST != 0) begin
      sh = w << (i * OUT_W);
      return sh[IN_W-1 -: OUT_W];
    end else begin
      sh = w >> (i * OUT_W);
      return sh[OUT_W-1:0];
    end
  endfunction

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    emit      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (!empty) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (req_data) begin
          emit = 1'b1;
          if (last) begin
            // Chain straight into the next word when one is waiting.
            if (!empty) load = 1'b1;
            else        state_nxt = ST_EMPTY;
          end
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Storage array carries no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {input_len, input_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      hold_data  <= '0;
      hold_len   <= '0;
      idx        <= '0;
      strobe_out <= 1'b0;
      data_out   <= '0;
      data_end   <= 1'b0;
    end else begin
      state      <= state_nxt;
      strobe_out <= emit;
      data_end   <= emit && last;
      if (emit) data_out <= slice_of(hold_data, idx);
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        {hold_len, hold_data} <= mem[rd_ptr[AW-1:0]];
        rd_ptr                <= rd_ptr + 1'b1;
        idx                   <= '0;
      end else if (emit) begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef WDC_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_cnt <= '0;
    end else if (strobe_in && full && (overflow_cnt != 16'hFFFF)) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end
`endif

endmodule
